// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the PISO frame transmitter.
package piso_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/piso_tx_always_ff_if.sv
// Word handshake and serial line bundle between a word source and the transmitter.
interface piso_tx_always_ff_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             txd;
  logic             busy;
  logic             done;

  modport master (output data, valid, input ready, txd, busy, done);
  modport slave  (input data, valid, output ready, txd, busy, done);
endinterface

// File: rtl/bit_tick_div.sv
// Bit-period divider: counts 0..DIV-1 while enabled, tick marks the last count.
module bit_tick_div
  import piso_tx_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic c,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned   DW   = cnt_w(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  // Held at zero while disabled so every frame starts on a fresh bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/piso_tx_always_ff.sv
// Parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
module piso_tx_always_ff
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic                c,
  input  logic                rst,
  piso_tx_always_ff_if.slave  bus
);

  localparam int unsigned   BW      = cnt_w(WIDTH);
  localparam logic [BW-1:0] LASTBIT = BW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tick;

  bit_tick_div #(
    .DIV (DIV)
  ) u_div (
    .c    (c),
    .rst  (rst),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d  = START;
          shreg_d  = bus.data;
          bitcnt_d = '0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == LASTBIT) begin
            state_d  = STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so txd stays a pure register output.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign bus.txd   = txd_q;
  assign bus.ready = ready_q;
  assign bus.busy  = ~ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_piso_tx_always_ff.sv
// Scoreboard bench: per-cycle line/status expectations queued at accept, popped each cycle.
module tb_piso_tx_always_ff;

  localparam int unsigned W0 = 8;
  localparam int unsigned D0 = 4;
  localparam int unsigned W1 = 1;
  localparam int unsigned D1 = 1;

  typedef struct packed {
    logic txd;
    logic done;
    logic ready;
  } exp_t;

  logic c = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 c = ~c;

  piso_tx_always_ff_if #(.WIDTH(W0)) bus0 ();
  piso_tx_always_ff_if #(.WIDTH(W1)) bus1 ();

  piso_tx_always_ff #(.WIDTH(W0), .DIV(D0)) dut0 (.c(c), .rst(rst), .bus(bus0.slave));
  piso_tx_always_ff #(.WIDTH(W1), .DIV(D1)) dut1 (.c(c), .rst(rst), .bus(bus1.slave));

  task automatic step();
    @(posedge c);
    #1;
  endtask

  // Expected cycles k+1 .. k+1+div*(w+2) for a word accepted at edge k.
  task automatic push_frame(input bit which, input int unsigned w, input int unsigned div,
                            input logic [31:0] d);
    int unsigned n;
    n = div * (w + 2) + 1;
    for (int unsigned j = 1; j <= n; j++) begin
      exp_t e;
      int unsigned slot;
      slot = (j - 1) / div;
      e.done  = 1'b0;
      e.ready = 1'b0;
      if (j == n) begin
        e.txd = 1'b1; e.done = 1'b1; e.ready = 1'b1;
      end else if (slot == 0) begin
        e.txd = 1'b0;
      end else if (slot <= w) begin
        e.txd = d[slot-1];
      end else begin
        e.txd = 1'b1;
      end
      if (which) sb1.push_back(e);
      else       sb0.push_back(e);
    end
  endtask

  // Steps until the accept edge has passed; ok=0 if ready never appeared.
  task automatic wait_accept(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((which ? bus1.ready : bus0.ready) === 1'b1) begin
        step();
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.valid = 1'b1; bus0.data = 8'h3C;
    bus1.valid = 1'b1; bus1.data = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({bus0.txd, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset0 cyc=%0d got txd/ready/busy/done=%b want 1100", i,
                 {bus0.txd, bus0.ready, bus0.busy, bus0.done});
      end
      n_tests++;
      if ({bus1.txd, bus1.ready, bus1.busy, bus1.done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset1 cyc=%0d got txd/ready/busy/done=%b want 1100", i,
                 {bus1.txd, bus1.ready, bus1.busy, bus1.done});
      end
    end
    rst = 1'b0;
    bus0.valid = 1'b0;
    bus1.valid = 1'b0;
    step();
    n_tests++;
    if ({bus0.txd, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_no_accept got txd/ready/busy/done=%b want 1100",
               {bus0.txd, bus0.ready, bus0.busy, bus0.done});
    end
  endtask

  task automatic test_single_frame();
    bit   ok;
    exp_t e;
    int   idx;
    bus0.data = 8'hA5; bus0.valid = 1'b1;
    wait_accept(1'b0, ok);
    bus0.valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_accept got timeout want accept"); end
    push_frame(1'b0, W0, D0, 32'hA5);
    idx = 0;
    while (sb0.size() > 0) begin
      e = sb0.pop_front();
      n_tests++;
      if ({bus0.txd, bus0.done, bus0.ready, bus0.busy} !== {e.txd, e.done, e.ready, ~e.ready}) begin
        n_fail++;
        $display("FAIL single cyc=k+%0d got txd/done/ready/busy=%b want %b", idx + 1,
                 {bus0.txd, bus0.done, bus0.ready, bus0.busy}, {e.txd, e.done, e.ready, ~e.ready});
      end
      idx++;
      step();
    end
    n_tests++;
    if ({bus0.done, bus0.ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_done_width got done/ready=%b want 01", {bus0.done, bus0.ready});
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    int   idx;
    bus0.data = 8'h00; bus0.valid = 1'b1;
    wait_accept(1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_accept got timeout want accept"); end
    push_frame(1'b0, W0, D0, 32'h00);
    idx = 0;
    while (sb0.size() > 0) begin
      e = sb0.pop_front();
      n_tests++;
      if ({bus0.txd, bus0.done, bus0.ready, bus0.busy} !== {e.txd, e.done, e.ready, ~e.ready}) begin
        n_fail++;
        $display("FAIL b2b cyc=k+%0d got txd/done/ready/busy=%b want %b", idx + 1,
                 {bus0.txd, bus0.done, bus0.ready, bus0.busy}, {e.txd, e.done, e.ready, ~e.ready});
      end
      if (idx == 20) bus0.data = 8'hFF;
      // valid is still high here, so edge k+41 accepts 0xFF
      if (idx == 40) push_frame(1'b0, W0, D0, 32'hFF);
      if (idx == 44) bus0.valid = 1'b0;
      idx++;
      step();
    end
    n_tests++;
    if ({bus0.done, bus0.ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_idle got done/ready=%b want 01", {bus0.done, bus0.ready});
    end
  endtask

  task automatic test_reset_mid_frame();
    bit   ok;
    exp_t e;
    int   idx;
    bus0.data = 8'h5A; bus0.valid = 1'b1;
    wait_accept(1'b0, ok);
    bus0.valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_accept got timeout want accept"); end
    push_frame(1'b0, W0, D0, 32'h5A);
    for (idx = 0; idx < 18; idx++) begin
      e = sb0.pop_front();
      n_tests++;
      if ({bus0.txd, bus0.done, bus0.ready, bus0.busy} !== {e.txd, e.done, e.ready, ~e.ready}) begin
        n_fail++;
        $display("FAIL abort_pre cyc=k+%0d got txd/done/ready/busy=%b want %b", idx + 1,
                 {bus0.txd, bus0.done, bus0.ready, bus0.busy}, {e.txd, e.done, e.ready, ~e.ready});
      end
      if (idx == 17) rst = 1'b1;
      step();
    end
    sb0.delete();
    rst = 1'b0;
    n_tests++;
    if ({bus0.txd, bus0.ready, bus0.busy, bus0.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL abort_reset got txd/ready/busy/done=%b want 1100",
               {bus0.txd, bus0.ready, bus0.busy, bus0.done});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({bus0.txd, bus0.ready, bus0.done} !== 3'b110) begin
        n_fail++;
        $display("FAIL abort_no_done cyc=%0d got txd/ready/done=%b want 110", i,
                 {bus0.txd, bus0.ready, bus0.done});
      end
    end
    bus0.data = 8'h81; bus0.valid = 1'b1;
    wait_accept(1'b0, ok);
    bus0.valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_reaccept got timeout want accept"); end
    push_frame(1'b0, W0, D0, 32'h81);
    idx = 0;
    while (sb0.size() > 0) begin
      e = sb0.pop_front();
      n_tests++;
      if ({bus0.txd, bus0.done, bus0.ready, bus0.busy} !== {e.txd, e.done, e.ready, ~e.ready}) begin
        n_fail++;
        $display("FAIL abort_post cyc=k+%0d got txd/done/ready/busy=%b want %b", idx + 1,
                 {bus0.txd, bus0.done, bus0.ready, bus0.busy}, {e.txd, e.done, e.ready, ~e.ready});
      end
      idx++;
      step();
    end
  endtask

  task automatic test_min_config();
    bit   ok;
    exp_t e;
    int   idx;
    for (int v = 1; v >= 0; v--) begin
      bus1.data = v[0]; bus1.valid = 1'b1;
      wait_accept(1'b1, ok);
      bus1.valid = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL min_accept d=%0d got timeout want accept", v); end
      push_frame(1'b1, W1, D1, 32'(v));
      idx = 0;
      while (sb1.size() > 0) begin
        e = sb1.pop_front();
        n_tests++;
        if ({bus1.txd, bus1.done, bus1.ready, bus1.busy} !== {e.txd, e.done, e.ready, ~e.ready}) begin
          n_fail++;
          $display("FAIL min d=%0d cyc=k+%0d got txd/done/ready/busy=%b want %b", v, idx + 1,
                   {bus1.txd, bus1.done, bus1.ready, bus1.busy}, {e.txd, e.done, e.ready, ~e.ready});
        end
        idx++;
        step();
      end
      n_tests++;
      if ({bus1.txd, bus1.done, bus1.ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL min_idle d=%0d got txd/done/ready=%b want 101", v,
                 {bus1.txd, bus1.done, bus1.ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_config();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
